// File: rtl/clk_div_pkg.sv
// Shared definitions for the divided-clock controller: FSM encoding and default width.
// Used by clk_div_ctrl (FSM, handshake) and clk_div_core (counter/toggle datapath).
package clk_div_pkg;

  localparam int CW_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } div_state_e;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and registered clock toggle; o_tc is combinational, outputs update one edge later.
// No backpressure: i_load wins over counting and restarts a low phase with i_half.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_half,
  input  logic          i_tick,
  output logic          o_clk,
  output logic          o_rise,
  output logic          o_fall,
  output logic          o_tc,
  output logic [CW-1:0] o_cur_half
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_cur_half;
  logic          r_clk;
  logic          r_rise;
  logic          r_fall;
  logic          w_tc;

  assign w_tc = i_tick && (r_cur_half != '0) && (r_cnt == (r_cur_half - CW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_cur_half <= '0;
      r_clk      <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
    end else if (i_load) begin
      // Loads only happen from IDLE (clock low) or on a high->low terminal count.
      r_cur_half <= i_half;
      r_cnt      <= '0;
      r_clk      <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= r_clk;
    end else if (w_tc) begin
      r_cnt  <= '0;
      r_clk  <= ~r_clk;
      r_rise <= ~r_clk;
      r_fall <= r_clk;
    end else begin
      if (i_tick) begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end
  end

  assign o_clk      = r_clk;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_tc       = w_tc;
  assign o_cur_half = r_cur_half;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divided-clock controller: active one cycle after an IDLE accept, first rise cur_half cycles later.
// cfg_ready drops while a new ratio is pending and returns on the falling edge that applies it.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_half,
  output logic          out_clk,
  output logic          out_rise,
  output logic          out_fall,
  output logic          active,
  output logic [CW-1:0] cur_half
);

  div_state_e    r_state;
  logic [CW-1:0] r_pend_half;
  logic          r_ready;
  logic          r_active;

  logic          w_accept;
  logic          w_tc;
  logic          w_out_clk;
  logic          w_switch;
  logic          w_load;
  logic          w_tick;
  logic [CW-1:0] w_load_half;

  assign w_accept    = cfg_valid && r_ready;
  // Pending ratio is only applied on a high->low terminal count.
  assign w_switch    = (r_state == ST_PEND) && w_tc && w_out_clk;
  assign w_load      = ((r_state == ST_IDLE) && w_accept && (cfg_half != '0)) || w_switch;
  assign w_load_half = (r_state == ST_PEND) ? r_pend_half : cfg_half;
  assign w_tick      = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pend_half <= '0;
      r_ready     <= 1'b1;
      r_active    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (cfg_half != '0)) begin
            r_state  <= ST_RUN;
            r_active <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_pend_half <= cfg_half;
            r_state     <= ST_PEND;
            r_ready     <= 1'b0;
          end
        end
        ST_PEND: begin
          if (w_switch) begin
            r_pend_half <= '0;
            r_ready     <= 1'b1;
            if (r_pend_half != '0) begin
              r_state <= ST_RUN;
            end else begin
              r_state  <= ST_IDLE;
              r_active <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_pend_half <= '0;
          r_ready     <= 1'b1;
          r_active    <= 1'b0;
        end
      endcase
    end
  end

  clk_div_core #(
    .CW (CW)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_half     (w_load_half),
    .i_tick     (w_tick),
    .o_clk      (w_out_clk),
    .o_rise     (out_rise),
    .o_fall     (out_fall),
    .o_tc       (w_tc),
    .o_cur_half (cur_half)
  );

  assign out_clk   = w_out_clk;
  assign cfg_ready = r_ready;
  assign active    = r_active;

endmodule
